ahb_periph_bridge: RTL and testbench

AHB-Lite subordinate that converts bus transfers into the simple peripheral register protocol (rd_en/wr_en/address/wr_data in, rd_data/ready/error back) used by the system peripherals such as the timer. It is the initiator end of that protocol. It sits between the AHB interconnect and one peripheral, handles wait states, peripheral errors and stuck reads, and returns the two-cycle AHB ERROR response.

---
 rtl/ahb_periph_bridge_if.sv | 27 ++
 rtl/ahb_periph_bridge.sv | 119 +++++++++++
 tb/tb_ahb_periph_bridge.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_periph_bridge_if.sv
// AHB-Lite subordinate-side signal bundle for ahb_periph_bridge.
// The master modport is the interconnect view; the slave modport is the bridge view.
interface ahb_periph_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hreadyout;
  logic                  hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_periph_bridge.sv
// AHB-Lite to simple peripheral register protocol bridge.
// Handles peripheral wait states, write errors, stuck reads (timeout) and
// unsupported transfers, and produces the two-cycle AHB ERROR response.
module ahb_periph_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ahb_periph_bridge_if.slave    bus,
  output logic                  rd_en,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  ready,
  input  logic                  error
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WCHK, S_RD, S_RDONE, S_ERR1, S_ERR2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         wait_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] hrdata_q;
  logic                  hreadyout_c;
  logic                  hresp_c;
  logic                  take;
  logic                  unsupported;
  logic                  unused_htrans0;

  // Only htrans[1] distinguishes a real transfer from IDLE/BUSY.
  assign unused_htrans0 = bus.htrans[0];

  assign unsupported = (bus.hsize != 3'b010) || (bus.haddr[1:0] != 2'b00);

  // Next-state and output decode; completion cycles may accept the next address phase.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    hreadyout_c = 1'b1;
    hresp_c     = 1'b0;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    take        = 1'b0;
    unique case (state_q)
      S_IDLE:  ;
      S_WR: begin
        wr_en       = 1'b1;
        hreadyout_c = 1'b0;
        state_d     = S_WCHK;
      end
      S_WCHK: begin
        if (error) begin
          hreadyout_c = 1'b0;
          state_d     = S_ERR1;
        end
      end
      S_RD: begin
        rd_en       = 1'b1;
        hreadyout_c = 1'b0;
        if (ready)                                 state_d = S_RDONE;
        else if (wait_cnt_q + CW'(1) == TIMEOUT_C) state_d = S_ERR1;
      end
      S_RDONE: ;
      S_ERR1: begin
        hreadyout_c = 1'b0;
        hresp_c     = 1'b1;
        state_d     = S_ERR2;
      end
      S_ERR2:  hresp_c = 1'b1;
      default: state_d = S_IDLE;
    endcase
    // hreadyout_c=1 marks a completion cycle (IDLE, WCHK-ok, RDONE, ERR2).
    if (hreadyout_c) begin
      if (bus.hsel && bus.hready && bus.htrans[1]) begin
        take = 1'b1;
        if (unsupported)     state_d = S_ERR1;
        else if (bus.hwrite) state_d = S_WR;
        else                 state_d = S_RD;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // State, latched address, read-wait counter and read-data register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      hrdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        addr_q     <= bus.haddr;
        wait_cnt_q <= '0;
      end else if (state_q == S_RD && !ready) begin
        wait_cnt_q <= wait_cnt_q + CW'(1);
      end
      if (state_q == S_RD && ready) hrdata_q <= rd_data;
    end
  end

  assign address       = addr_q;
  assign wr_data       = wr_en ? bus.hwdata : '0;
  assign bus.hrdata    = hrdata_q;
  assign bus.hreadyout = hreadyout_c;
  assign bus.hresp     = hresp_c;

endmodule

// File: tb/tb_ahb_periph_bridge.sv
// Directed testbench for ahb_periph_bridge with hand-computed expectations.
module tb_ahb_periph_bridge;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_en, wr_en;
  logic [AW-1:0] address;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data = '0;
  logic          ready   = 1'b0;
  logic          error   = 1'b0;

  int total = 0;
  int bad   = 0;

  ahb_periph_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  // Single subordinate on the bus: bus-wide hready follows our own hreadyout.
  assign bus.hready = bus.hreadyout;

  always #5 clk = ~clk;

  ahb_periph_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .rd_en   (rd_en),
    .wr_en   (wr_en),
    .address (address),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .ready   (ready),
    .error   (error)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
    bus.hsel   = 1'b1;
    bus.htrans = 2'b10;
    bus.haddr  = a;
    bus.hwrite = w;
    bus.hsize  = sz;
  endtask

  task automatic bus_idle();
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.haddr  = '0;
    bus.hwrite = 1'b0;
    bus.hsize  = 3'b010;
  endtask

  // Runs a read/error data phase until hreadyout=1; ready rises after ready_after cycles.
  task automatic data_phase(input int ready_after, input logic [31:0] rdat,
                            output int cyc, output int nrd, output int nwr, output int both);
    bit done;
    cyc = 0; nrd = 0; nwr = 0; both = 0; done = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      bus_idle();
      ready   = (i >= ready_after);
      rd_data = rdat;
      error   = 1'b0;
      #1;
      cyc++;
      if (rd_en) nrd++;
      if (wr_en) nwr++;
      if (rd_en && wr_en) both++;
      if (bus.hreadyout) begin
        done = 1;
        break;
      end
    end
    check("phase_done", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nrd, nwr, both;
    bus_idle();
    bus.hwdata = '0;

    // Reset values
    step();
    step();
    check("rst_hreadyout", 32'(bus.hreadyout), 32'd1);
    check("rst_hresp",     32'(bus.hresp),     32'd0);
    check("rst_hrdata",    bus.hrdata,         32'd0);
    check("rst_rd_en",     32'(rd_en),         32'd0);
    check("rst_wr_en",     32'(wr_en),         32'd0);
    check("rst_address",   address,            32'd0);
    check("rst_wr_data",   wr_data,            32'd0);
    rst = 1'b0;
    step();

    // Write 0x4000_0004 <- 0x64, peripheral OK
    addr_phase(32'h4000_0004, 1'b1, 3'b010);
    #1 check("w1_accept_rdy", 32'(bus.hreadyout), 32'd1);
    step();
    bus_idle();
    bus.hwdata = 32'h0000_0064;
    #1;
    check("w1_wr_en",    32'(wr_en),         32'd1);
    check("w1_rd_en",    32'(rd_en),         32'd0);
    check("w1_address",  address,            32'h4000_0004);
    check("w1_wr_data",  wr_data,            32'h0000_0064);
    check("w1_stall",    32'(bus.hreadyout), 32'd0);
    step();
    error = 1'b0;
    #1;
    check("w1_wr_en_low", 32'(wr_en),         32'd0);
    check("w1_wr_data0",  wr_data,            32'd0);
    check("w1_done_rdy",  32'(bus.hreadyout), 32'd1);
    check("w1_done_resp", 32'(bus.hresp),     32'd0);

    // Read 0x4000_0008, ready immediately, rd_data=0x0A
    step();
    addr_phase(32'h4000_0008, 1'b0, 3'b010);
    data_phase(0, 32'h0000_000A, cyc, nrd, nwr, both);
    check("r1_cycles", 32'(cyc),        32'd2);
    check("r1_rd_en",  32'(nrd),        32'd1);
    check("r1_wr_en",  32'(nwr),        32'd0);
    check("r1_hrdata", bus.hrdata,      32'h0000_000A);
    check("r1_hresp",  32'(bus.hresp),  32'd0);
    check("r1_addr",   address,         32'h4000_0008);

    // Write 0x4000_0010 with peripheral error
    step();
    addr_phase(32'h4000_0010, 1'b1, 3'b010);
    step();
    bus_idle();
    bus.hwdata = 32'h0000_0055;
    #1 check("we_wr_en", 32'(wr_en), 32'd1);
    step();
    error = 1'b1;
    #1;
    check("we_wchk_rdy", 32'(bus.hreadyout), 32'd0);
    step();
    error = 1'b0;
    #1;
    check("we_err1_rdy",  32'(bus.hreadyout), 32'd0);
    check("we_err1_resp", 32'(bus.hresp),     32'd1);
    step();
    #1;
    check("we_err2_rdy",  32'(bus.hreadyout), 32'd1);
    check("we_err2_resp", 32'(bus.hresp),     32'd1);
    check("we_hrdata",    bus.hrdata,         32'h0000_000A);

    // Read 0x4000_0014 with 5 wait cycles, then rd_data=1
    step();
    addr_phase(32'h4000_0014, 1'b0, 3'b010);
    data_phase(5, 32'h0000_0001, cyc, nrd, nwr, both);
    check("rw_cycles", 32'(cyc),       32'd7);
    check("rw_rd_en",  32'(nrd),       32'd6);
    check("rw_hrdata", bus.hrdata,     32'h0000_0001);
    check("rw_hresp",  32'(bus.hresp), 32'd0);

    // Read with ready stuck low: timeout after TO RD cycles
    step();
    addr_phase(32'h4000_0018, 1'b0, 3'b010);
    data_phase(1000, 32'hDEAD_BEEF, cyc, nrd, nwr, both);
    check("to_cycles", 32'(cyc),       32'd18);
    check("to_rd_en",  32'(nrd),       32'd16);
    check("to_hresp",  32'(bus.hresp), 32'd1);
    check("to_hrdata", bus.hrdata,     32'h0000_0001);

    // Unsupported size (byte)
    step();
    addr_phase(32'h4000_0004, 1'b1, 3'b000);
    data_phase(0, 32'h0, cyc, nrd, nwr, both);
    check("us_cycles", 32'(cyc),       32'd2);
    check("us_strobe", 32'(nrd + nwr), 32'd0);
    check("us_hresp",  32'(bus.hresp), 32'd1);

    // Unsupported alignment
    step();
    addr_phase(32'h4000_0002, 1'b0, 3'b010);
    data_phase(0, 32'h0, cyc, nrd, nwr, both);
    check("ua_cycles", 32'(cyc),       32'd2);
    check("ua_strobe", 32'(nrd + nwr), 32'd0);
    check("ua_hresp",  32'(bus.hresp), 32'd1);
    check("ua_hrdata", bus.hrdata,     32'h0000_0001);

    // Back-to-back write then read, reset during the read
    step();
    addr_phase(32'h4000_0020, 1'b1, 3'b010);
    step();
    bus_idle();
    bus.hwdata = 32'h0000_0077;
    #1 check("bb_wr_en", 32'(wr_en), 32'd1);
    step();
    error = 1'b0;
    addr_phase(32'h4000_0024, 1'b0, 3'b010);
    #1 check("bb_wchk_rdy", 32'(bus.hreadyout), 32'd1);
    step();
    bus_idle();
    ready = 1'b0;
    #1;
    check("bb_rd_en",    32'(rd_en), 32'd1);
    check("bb_rd_addr",  address,    32'h4000_0024);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("bb_rst_rd_en", 32'(rd_en),         32'd0);
    check("bb_rst_rdy",   32'(bus.hreadyout), 32'd1);
    check("bb_rst_resp",  32'(bus.hresp),     32'd0);
    check("bb_rst_addr",  address,            32'd0);
    check("bb_rst_hrd",   bus.hrdata,         32'd0);
    addr_phase(32'h4000_0028, 1'b0, 3'b010);
    data_phase(0, 32'h1234_5678, cyc, nrd, nwr, both);
    check("pr_cycles", 32'(cyc),       32'd2);
    check("pr_rd_en",  32'(nrd),       32'd1);
    check("pr_hrdata", bus.hrdata,     32'h1234_5678);
    check("pr_hresp",  32'(bus.hresp), 32'd0);
    check("pr_both",   32'(both),      32'd0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
